// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared definitions for the I2C codec-control responder.
// Holds the responder state encoding, the default device address of the
// WM8731-style codec (7'h1A, i.e. write byte 0x34) and small helpers.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ACK_ADDR  = 3'd2,
      BYTE1     = 3'd3,
      ACK1      = 3'd4,
      BYTE2     = 3'd5,
      ACK2      = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

   localparam logic [6:0] DEV_ADDR_WM8731 = 7'h1A;
   localparam logic [3:0] BITS_PER_BYTE   = 4'd8;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge -- input conditioning for the I2C responder.
// Synchronises raw SCL/SDA into the clk domain and derives SCL edges and
// bus START/STOP conditions from the synchronised values and their
// one-cycle-delayed copies.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   scl_raw, sda_raw  asynchronous pad inputs
//   sda               synchronised SDA level (data bit source)
//   scl_rise/scl_fall one-cycle pulses on synchronised SCL edges
//   start/stop        one-cycle pulses on bus START / STOP conditions
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_raw,
   input  logic sda_raw,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync_r;
   logic [SYNC_STAGES-1:0] sda_sync_r;
   logic                   scl_d_r;
   logic                   sda_d_r;
   logic                   scl_s;
   logic                   sda_s;

   // Synchroniser chains plus one delayed copy for edge detection; reset to idle-bus ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_sync_r <= {SYNC_STAGES{1'b1}};
         sda_sync_r <= {SYNC_STAGES{1'b1}};
         scl_d_r    <= 1'b1;
         sda_d_r    <= 1'b1;
      end else begin
         scl_sync_r[0] <= scl_raw;
         sda_sync_r[0] <= sda_raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync_r[i] <= scl_sync_r[i-1];
            sda_sync_r[i] <= sda_sync_r[i-1];
         end
         scl_d_r <= scl_s;
         sda_d_r <= sda_s;
      end
   end

   assign scl_s    = scl_sync_r[SYNC_STAGES-1];
   assign sda_s    = sda_sync_r[SYNC_STAGES-1];
   assign sda      = sda_s;
   assign scl_rise = scl_s & ~scl_d_r;
   assign scl_fall = ~scl_s & scl_d_r;
   // SCL must be high in both samples so an SDA change that lands in the
   // same cycle as an SCL edge is not mistaken for START/STOP.
   assign start    = scl_s & scl_d_r & sda_d_r & ~sda_s;
   assign stop     = scl_s & scl_d_r & ~sda_d_r & sda_s;

endmodule

// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder -- write-only I2C target for codec register writes.
// Accepts frames START, {DEV_ADDR,0}, byte1, byte2 and reports a 7-bit
// register address (byte1[7:1]) with 9-bit data ({byte1[0], byte2}).
// Ports:
//   clk, reset     system clock (>= 16x SCL), synchronous active-high reset
//   scl_in, sda_in raw asynchronous bus inputs
//   sda_oe         1 = pull SDA low (acknowledge)
//   wr_valid       one-cycle pulse per accepted register write
//   wr_addr        register address of the last accepted write
//   wr_data        register data of the last accepted write
//   write_count    number of accepted writes, saturating at 8'hFF
//   busy           high whenever the responder is not idle
module i2c_codec_responder
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEV_ADDR_WM8731,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic [7:0] write_count,
   output logic       busy
);

   logic   sda_s;
   logic   scl_rise_s;
   logic   scl_fall_s;
   logic   start_s;
   logic   stop_s;

   state_t state_r;
   logic [7:0] shift_r;
   logic [3:0] bit_cnt_r;
   logic [7:0] byte1_r;

   i2c_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk      (clk),
      .reset    (reset),
      .scl_raw  (scl_in),
      .sda_raw  (sda_in),
      .sda      (sda_s),
      .scl_rise (scl_rise_s),
      .scl_fall (scl_fall_s),
      .start    (start_s),
      .stop     (stop_s)
   );

   // Responder FSM: bit shifting, acknowledge drive and write reporting.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         shift_r     <= 8'h00;
         bit_cnt_r   <= 4'd0;
         byte1_r     <= 8'h00;
         sda_oe      <= 1'b0;
         wr_valid    <= 1'b0;
         wr_addr     <= 7'h00;
         wr_data     <= 9'h000;
         write_count <= 8'h00;
         busy        <= 1'b0;
      end else begin
         wr_valid <= 1'b0;
         // Bus conditions win over any SCL edge seen in the same cycle.
         if (start_s) begin
            state_r   <= ADDR;
            bit_cnt_r <= 4'd0;
            sda_oe    <= 1'b0;
            busy      <= 1'b1;
         end else if (stop_s) begin
            state_r <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state_r)
               IDLE, WAIT_STOP: begin
                  sda_oe <= 1'b0;
               end
               ADDR, BYTE1, BYTE2: begin
                  if (scl_rise_s && (bit_cnt_r < BITS_PER_BYTE)) begin
                     shift_r   <= {shift_r[6:0], sda_s};
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end else if (scl_fall_s && (bit_cnt_r == BITS_PER_BYTE)) begin
                     // First SCL low after the eighth bit: decide ACK or NACK.
                     bit_cnt_r <= 4'd0;
                     case (state_r)
                        ADDR: begin
                           if ((shift_r[7:1] == DEV_ADDR) && (shift_r[0] == 1'b0)) begin
                              state_r <= ACK_ADDR;
                              sda_oe  <= 1'b1;
                           end else begin
                              state_r <= WAIT_STOP;
                              sda_oe  <= 1'b0;
                           end
                        end
                        BYTE1: begin
                           byte1_r <= shift_r;
                           state_r <= ACK1;
                           sda_oe  <= 1'b1;
                        end
                        BYTE2: begin
                           state_r     <= ACK2;
                           sda_oe      <= 1'b1;
                           wr_valid    <= 1'b1;
                           wr_addr     <= byte1_r[7:1];
                           wr_data     <= {byte1_r[0], shift_r};
                           write_count <= sat_inc8(write_count);
                        end
                        default: begin
                           state_r <= WAIT_STOP;
                           sda_oe  <= 1'b0;
                        end
                     endcase
                  end else begin
                     sda_oe <= 1'b0;
                  end
               end
               ACK_ADDR, ACK1, ACK2: begin
                  // Hold the ACK through the ninth clock; release on its falling edge.
                  if (scl_fall_s) begin
                     sda_oe <= 1'b0;
                     case (state_r)
                        ACK_ADDR: state_r <= BYTE1;
                        ACK1:     state_r <= BYTE2;
                        ACK2:     state_r <= WAIT_STOP;
                        default:  state_r <= WAIT_STOP;
                     endcase
                  end else begin
                     sda_oe <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  sda_oe  <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/i2c_codec_responder.md
I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, SHALL be the 7-bit device address the block answers (write byte 0x34).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the flip-flop depth of the SCL/SDA input synchronisers.
REQ-003 clk  input  1  system clock; SHALL run at least 16x the SCL rate.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl_in  input  1  raw SCL from the pad, asynchronous.
REQ-006 sda_in  input  1  raw SDA from the pad, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 wr_valid  output  1  one-cycle pulse; a complete register write was accepted.
REQ-009 wr_addr  output  7  register address (first data byte [7:1]).
REQ-010 wr_data  output  9  register data: {first data byte [0], second data byte}.
REQ-011 write_count  output  8  accepted-write count, saturating at 8'hFF.
REQ-012 busy  output  1  1 while state is not IDLE.

Function
REQ-013 Both inputs SHALL pass through SYNC_STAGES flip-flops; all decisions SHALL use only synchronised values and their one-cycle-delayed copies.
REQ-014 START = synchronised SDA falls while SCL high; STOP = synchronised SDA rises while SCL high.
REQ-015 Data bits SHALL be sampled on the synchronised SCL rising edge, MSB first, into an 8-bit shift register; a 4-bit bit counter SHALL count 0..8.
REQ-016 States SHALL be IDLE, ADDR, ACK_ADDR, BYTE1, ACK1, BYTE2, ACK2, WAIT_STOP.
REQ-017 START in any state SHALL go to ADDR, clear the bit counter and release sda_oe in the same cycle.
REQ-018 STOP in any state SHALL go to IDLE and release sda_oe in the same cycle; no wr_valid is produced unless ACK2 was already reached.
REQ-019 ADDR: after 8 bits, if byte[7:1] == DEV_ADDR and byte[0] == 0, the block SHALL go to ACK_ADDR; otherwise it SHALL go to WAIT_STOP without driving SDA. Read requests SHALL be NACKed.
REQ-020 ACK states: sda_oe SHALL assert at the first SCL falling edge after bit 8, hold through the ninth SCL high phase, and release at the next SCL falling edge.
REQ-021 Transitions: ACK_ADDR->BYTE1, ACK1->BYTE2, ACK2->WAIT_STOP, each taken at the SCL falling edge that releases sda_oe.
REQ-022 Latency: sda_oe SHALL change no later than SYNC_STAGES+2 clk cycles after the raw SCL falling edge.
REQ-023 BYTE1 complete: the block SHALL latch the byte and go to ACK1. BYTE2 complete: it SHALL latch the byte and go to ACK2.
REQ-024 wr_valid SHALL pulse exactly once, in the cycle sda_oe asserts for ACK2. wr_addr and wr_data SHALL update in that same cycle and hold until the next accepted write.
REQ-025 write_count SHALL increment with each wr_valid pulse and hold at 8'hFF.
REQ-026 WAIT_STOP SHALL ignore all further bytes and never assert sda_oe, so extra bytes are NACKed; it exits only on START or STOP.
REQ-027 An SCL edge and a START/STOP in the same cycle: START/STOP SHALL take priority.

Reset
REQ-028 While reset is high the block SHALL hold these values: state=IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, write_count=0, busy=0, shift register and bit counter=0, synchronisers=1 (idle bus).
REQ-029 Reset asserted mid-transfer, including during an ACK, SHALL release sda_oe on the next clk edge.
REQ-030 After reset the block SHALL ignore bus activity until the next START.

Structure
REQ-031 A shared package i2c_pkg SHALL hold the state enum and the default device address constant 7'h1A (DEV_ADDR_WM8731).
REQ-032 One sub-module, i2c_sync_edge, SHALL hold the synchronisers and the rise, fall, START and STOP detection; the FSM, shifter and outputs SHALL stay in i2c_codec_responder.

Verification
REQ-033 Frame START,0x34,0x0C,0x10,STOP -> three ACKs; wr_valid pulses once; wr_addr=7'h06; wr_data=9'h010; write_count=1.
REQ-034 Frame START,0x36,... -> sda_oe stays 0 for the whole frame; no wr_valid; busy until STOP.
REQ-035 Frame START,0x35 (read) -> address NACKed; no wr_valid.
REQ-036 START,0x34,0x12,STOP (one data byte) -> two ACKs; no wr_valid; state IDLE after STOP.
REQ-037 Repeated START after bit 4 of BYTE1, then 0x34,0x12,0x01,STOP -> wr_addr=7'h09; wr_data=9'h001; exactly one wr_valid.
REQ-038 Reset pulsed during ACK1 -> sda_oe=0 one cycle later; a following valid frame is accepted with write_count=1.
